emesh_fifo_drain: RTL
=====================

Name: emesh_fifo_drain

Overview:
Read-side drain stage sitting directly downstream of the 104-bit async FIFO, in the FIFO read-clock domain. It issues rd_en to the FIFO and captures dout when valid is asserted. Captured words go into a 2-entry skid buffer, which presents them as an emesh access/packet stream with wait backpressure. It guarantees no data loss under backpressure, sustains one packet per cycle, and exposes sticky protocol-error flags and a delivered-packet counter for debug.

Parameters:
PW, 104, packet width (must match FIFO DW)
CW, 16, width of delivered-packet counter

Ports:
clk  input  1  read-side clock (same clock as the FIFO rd_clk)
nreset  input  1  asynchronous active-low reset
en  input  1  drain enable; 0 blocks new FIFO reads but lets the buffer drain
fifo_empty  input  1  FIFO empty flag
fifo_valid  input  1  FIFO read data valid, 1 cycle after an accepted rd_en
fifo_dout  input  PW  FIFO read data
fifo_rd_en  output  1  FIFO read request
access_out  output  1  packet valid to downstream
packet_out  output  PW  packet to downstream (head of skid buffer)
wait_in  input  1  downstream backpressure
pkt_count  output  CW  delivered-packet count, wraps modulo 2^CW
err_overflow  output  1  sticky: fifo_valid arrived while buffer full and not popping
err_unexp  output  1  sticky: fifo_valid arrived with no read in flight

Behaviour:
- Reset (nreset low, asynchronous): count=0, inflight=0, buffer entries=0, pkt_count=0, err_*=0, fifo_rd_en=0, access_out=0, packet_out=0.
- State: count (0..2, registered buffer occupancy); inflight (registered copy of previous cycle's fifo_rd_en).
- pop = access_out & ~wait_in. Pop occurs in the same cycle as the handshake.
- access_out = (count != 0). packet_out = entry[head]; it is 0 when count==0.
- fifo_rd_en = en & ~fifo_empty & ((count + inflight - pop) < 2). This is combinational. Computing it with the pop term allows 1 packet/cycle steady state.
- Capture: when fifo_valid, write fifo_dout at the tail.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push on an empty buffer: the word appears on packet_out the next cycle. Total latency from rd_en to access_out is 2 cycles.
- Buffer is 2 entries with head/tail pointers that wrap 1->0. Entries are FIFO ordered. packet_out is stable while access_out & wait_in.
- Overflow (fifo_valid & count==2 & ~pop): set err_overflow and drop the word. The buffer is unchanged. Cannot occur with correct rd_en logic; it is a checker hook.
- Unexpected (fifo_valid & ~inflight): set err_unexp and still capture the word if space allows. Exception: the first cycle after nreset release does not flag or capture.
- pkt_count increments by 1 on every pop and wraps from 2^CW-1 to 0.
- en deasserted: fifo_rd_en=0 from that cycle onward. A word already in flight is still captured, and the buffer continues to drain.
- wait_in held high: at most 2 reads are outstanding (count + inflight ≤ 2). fifo_rd_en stays low until a pop occurs.
- Mid-operation reset: buffered and in-flight data are discarded. The FIFO is reset separately.
- Error flags clear only on reset.

Test Plan:
1. Reset then idle: fifo_empty=1 and en=1 -> fifo_rd_en=0, access_out=0, pkt_count=0, err_*=0.
2. Streaming: preload 8 words 0x1..0x8 and hold wait_in=0 -> access_out high for 8 consecutive cycles starting 2 cycles after the first rd_en, packets in order 0x1..0x8, pkt_count=8.
3. Backpressure: 6 words with wait_in=1 for 10 cycles -> exactly 2 rd_en pulses, count=2, packet_out=word1 stable. After release, words 1..6 arrive in order, err_overflow=0.
4. Simultaneous push/pop with alternating wait_in (1,0,1,0...) -> no loss or duplication, 20 words delivered in order, count never exceeds 2.
5. en dropped in the cycle after a rd_en -> the in-flight word is captured and delivered, and no further rd_en is issued while en=0.
6. Inject fifo_valid with no prior rd_en -> err_unexp=1 and stays set. Then force count=2 with wait_in=1 and inject a third fifo_valid -> err_overflow=1 and packet_out unchanged. Assert nreset -> all outputs 0.

Source files
------------

// File: rtl/emesh_fifo_drain.sv
// emesh_fifo_drain
// Read-side drain stage for the 104-bit async FIFO. It issues reads, captures
// the returned words into a 2-entry skid buffer and presents them as an emesh
// access/packet stream with wait backpressure. It also keeps a delivered-packet
// counter and sticky protocol-error flags for debug.
module emesh_fifo_drain #(
  parameter int PW = 104,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic          fifo_valid,
  input  logic [PW-1:0] fifo_dout,
  output logic          fifo_rd_en,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in,
  output logic [CW-1:0] pkt_count,
  output logic          err_overflow,
  output logic          err_unexp
);

  // Skid buffer storage and pointers
  logic [PW-1:0] mem_reg [0:1];
  logic          head_reg;
  logic          tail_reg;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;

  // Previous-cycle rd_en, i.e. a word is due from the FIFO this cycle
  logic          inflight_reg;

  // Low for exactly the first cycle after reset release. Reads are held off
  // and any stray fifo_valid in that cycle is ignored.
  logic          started_reg;

  logic [CW-1:0] pkt_count_reg;
  logic          err_overflow_reg;
  logic          err_unexp_reg;

  logic          pop;
  logic          cap_valid;
  logic          push;
  logic          overflow;
  logic          unexp;
  logic [2:0]    occ_after_pop;

  // Handshake, read-request and capture decisions
  always_comb begin
    pop           = (count_reg != 2'd0) & ~wait_in;
    // Counting the pop lets a new read issue in the same cycle a slot frees up,
    // which sustains one packet per cycle.
    occ_after_pop = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
    fifo_rd_en    = started_reg & en & ~fifo_empty & (occ_after_pop < 3'd2);
    cap_valid     = started_reg & fifo_valid;
    push          = cap_valid & ((count_reg != 2'd2) | pop);
    overflow      = cap_valid & (count_reg == 2'd2) & ~pop;
    unexp         = cap_valid & ~inflight_reg;
  end

  // Next occupancy from the push/pop combination
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Buffer entry writes at the tail. When full with a simultaneous pop, the
  // tail aliases the head being consumed this cycle, so overwriting it is safe.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[tail_reg] <= fifo_dout;
    end
  end

  // Pointers, occupancy, in-flight tracking and the start-up flag
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head_reg     <= 1'b0;
      tail_reg     <= 1'b0;
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      started_reg  <= 1'b0;
    end else begin
      started_reg  <= 1'b1;
      inflight_reg <= fifo_rd_en;
      count_reg    <= count_next;
      if (push) begin
        tail_reg <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
    end
  end

  // Debug: delivered-packet counter (wraps) and sticky error flags
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pkt_count_reg    <= '0;
      err_overflow_reg <= 1'b0;
      err_unexp_reg    <= 1'b0;
    end else begin
      if (pop) begin
        pkt_count_reg <= pkt_count_reg + CW'(1);
      end
      if (overflow) begin
        err_overflow_reg <= 1'b1;
      end
      if (unexp) begin
        err_unexp_reg <= 1'b1;
      end
    end
  end

  // Head of the buffer is presented directly; zero when empty
  always_comb begin
    access_out   = (count_reg != 2'd0);
    packet_out   = access_out ? mem_reg[head_reg] : '0;
    pkt_count    = pkt_count_reg;
    err_overflow = err_overflow_reg;
    err_unexp    = err_unexp_reg;
  end

endmodule
